// File: rtl/bpred_ctr_update.sv
// Retire-side updater for the bimodal 2-bit counter table: queues resolved branches,
// reads each counter, saturates it toward the outcome and writes it back one cycle later.
module bpred_ctr_update #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 2,
    parameter int Q_DEPTH    = 4,
    parameter int Q_LOG      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  upd_valid_i,
    input  logic [SRAM_INDEX-1:0] upd_index_i,
    input  logic                  upd_taken_i,
    output logic                  upd_ready_o,
    output logic                  re1_o,
    output logic [SRAM_INDEX-1:0] addr1_o,
    input  logic [SRAM_WIDTH-1:0] data1_i,
    output logic                  we_o,
    output logic [SRAM_INDEX-1:0] addrWr_o,
    output logic [SRAM_WIDTH-1:0] data_o,
    output logic [Q_LOG:0]        occupancy_o,
    output logic                  busy_o
);

    if (SRAM_DEPTH != (1 << SRAM_INDEX) || Q_DEPTH != (1 << Q_LOG) || SRAM_WIDTH != 2) begin : g_param_check
        $error("bpred_ctr_update: inconsistent table/queue parameters");
    end

    localparam logic [Q_LOG:0]        Q_FULL  = (Q_LOG+1)'(Q_DEPTH);
    localparam logic [SRAM_WIDTH-1:0] CTR_MAX = '1;

    function automatic logic [SRAM_WIDTH-1:0] sat_next(input logic [SRAM_WIDTH-1:0] cur,
                                                       input logic                  taken);
        if (taken)
            return (cur == CTR_MAX) ? CTR_MAX : cur + 1'b1;
        else
            return (cur == '0) ? '0 : cur - 1'b1;
    endfunction

    logic [SRAM_INDEX-1:0] q_idx [Q_DEPTH];
    logic                  q_tkn [Q_DEPTH];
    logic [Q_LOG-1:0]      head;
    logic [Q_LOG-1:0]      tail;
    logic [Q_LOG:0]        occ;

    logic                  push;
    logic                  pop;
    logic [SRAM_INDEX-1:0] head_idx_p0;
    logic                  head_tkn_p0;
    logic [SRAM_WIDTH-1:0] cur_p0;
    logic [SRAM_WIDTH-1:0] next_p0;

    logic                  vld_p1;
    logic [SRAM_INDEX-1:0] addr_p1;
    logic [SRAM_WIDTH-1:0] ctr_p1;

    assign upd_ready_o = (occ != Q_FULL);
    assign push        = upd_valid_i && upd_ready_o;
    assign pop         = (occ != '0);

    // Stage p0: FIFO head drives read port 1; bypass covers a write still in flight
    always_comb begin
        head_idx_p0 = q_idx[head];
        head_tkn_p0 = q_tkn[head];
        cur_p0      = (vld_p1 && addr_p1 == head_idx_p0) ? ctr_p1 : data1_i;
        next_p0     = sat_next(cur_p0, head_tkn_p0);
    end

    assign re1_o   = pop;
    assign addr1_o = pop ? head_idx_p0 : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail] <= upd_index_i;
            q_tkn[tail] <= upd_taken_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Stage p1: write-port register, loaded on every dequeue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            ctr_p1  <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                addr_p1 <= head_idx_p0;
                ctr_p1  <= next_p0;
            end
        end
    end

    assign we_o        = vld_p1;
    assign addrWr_o    = addr_p1;
    assign data_o      = ctr_p1;
    assign occupancy_o = occ;
    assign busy_o      = (occ != '0) || vld_p1;

endmodule
